// File: rtl/control_barrido_ventana.sv
`default_nettype none
// ============================================================================
// Module   : control_barrido_ventana
// Purpose  : Raster-order sweep of a 2x2 pixel window over a frame memory.
//            For every window it reads 4 pixels, strobes the matching window
//            register, then offers the window to the filter core using a
//            valid/ready handshake. It pulses terminado after the last window.
// Revision : 1.0 - initial release
// ============================================================================
module control_barrido_ventana #(
  parameter int ANCHO = 8,
  parameter int ALTO  = 8,
  parameter int DIR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iniciar,
  output logic             leer,
  output logic [DIR_W-1:0] dir_lectura,
  input  logic [7:0]       dato_mem,
  output logic [3:0]       guardar_dato,
  output logic [1:0]       valor_pixel,
  output logic             filtro_valido,
  input  logic             filtro_listo,
  output logic [DIR_W-1:0] dir_escritura,
  output logic             ocupado,
  output logic             terminado
);

  typedef enum logic [2:0] {
    E_INICIO  = 3'd0,
    E_LEER    = 3'd1,
    E_ULTIMO  = 3'd2,
    E_ENTREGA = 3'd3,
    E_FIN     = 3'd4
  } estado_t;

  localparam logic [DIR_W-1:0] c_ANCHO    = DIR_W'(ANCHO);
  localparam logic [DIR_W-1:0] c_ANCHO_M1 = DIR_W'(ANCHO - 1);
  localparam logic [DIR_W-1:0] c_X_MAX    = DIR_W'(ANCHO - 2);
  localparam logic [DIR_W-1:0] c_Y_MAX    = DIR_W'(ALTO - 2);

  estado_t          r_estado, w_estado_sig;
  logic [DIR_W-1:0] r_x, r_y, w_x_sig, w_y_sig;
  logic [1:0]       r_k, w_k_sig;
  logic [3:0]       r_guardar_dato;
  logic [1:0]       r_valor_pixel;
  logic [DIR_W-1:0] w_fila, w_col, w_dir_rd, w_dir_wr;
  logic             w_ultima;
  logic             w_unused_dato;

  // Pixel data goes straight to the window registers; this block never looks at it.
  assign w_unused_dato = ^dato_mem;

  // Pixel k: bit 0 selects the right-hand column, bit 1 the lower row.
  assign w_fila   = r_y + {{(DIR_W-1){1'b0}}, r_k[1]};
  assign w_col    = r_x + {{(DIR_W-1){1'b0}}, r_k[0]};
  assign w_dir_rd = w_fila * c_ANCHO + w_col;
  assign w_dir_wr = r_y * c_ANCHO_M1 + r_x;
  assign w_ultima = (r_x == c_X_MAX) && (r_y == c_Y_MAX);

  assign guardar_dato = r_guardar_dato;
  assign valor_pixel  = r_valor_pixel;

  // Next-state, counter updates and Moore outputs of the sweep sequencer.
  always_comb begin
    w_estado_sig  = r_estado;
    w_x_sig       = r_x;
    w_y_sig       = r_y;
    w_k_sig       = r_k;
    leer          = 1'b0;
    dir_lectura   = '0;
    filtro_valido = 1'b0;
    dir_escritura = '0;
    ocupado       = 1'b1;
    terminado     = 1'b0;
    case (r_estado)
      E_INICIO: begin
        ocupado = 1'b0;
        if (iniciar) begin
          w_estado_sig = E_LEER;
          w_x_sig      = '0;
          w_y_sig      = '0;
          w_k_sig      = 2'd0;
        end
      end
      E_LEER: begin
        leer        = 1'b1;
        dir_lectura = w_dir_rd;
        w_k_sig     = r_k + 2'd1;
        if (r_k == 2'd3) begin
          w_estado_sig = E_ULTIMO;
        end
      end
      E_ULTIMO: begin
        // Memory returns pixel 3 during this cycle; its strobe is issued here.
        w_estado_sig = E_ENTREGA;
      end
      E_ENTREGA: begin
        filtro_valido = 1'b1;
        dir_escritura = w_dir_wr;
        if (filtro_listo) begin
          if (w_ultima) begin
            w_estado_sig = E_FIN;
          end else begin
            w_estado_sig = E_LEER;
            w_k_sig      = 2'd0;
            if (r_x == c_X_MAX) begin
              w_x_sig = '0;
              w_y_sig = r_y + {{(DIR_W-1){1'b0}}, 1'b1};
            end else begin
              w_x_sig = r_x + {{(DIR_W-1){1'b0}}, 1'b1};
            end
          end
        end
      end
      E_FIN: begin
        terminado    = 1'b1;
        w_estado_sig = E_INICIO;
        w_x_sig      = '0;
        w_y_sig      = '0;
        w_k_sig      = 2'd0;
      end
      default: begin
        ocupado      = 1'b0;
        w_estado_sig = E_INICIO;
        w_x_sig      = '0;
        w_y_sig      = '0;
        w_k_sig      = 2'd0;
      end
    endcase
  end

  // State and window-position registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado <= E_INICIO;
      r_x      <= '0;
      r_y      <= '0;
      r_k      <= 2'd0;
    end else begin
      r_estado <= w_estado_sig;
      r_x      <= w_x_sig;
      r_y      <= w_y_sig;
      r_k      <= w_k_sig;
    end
  end

  // Load strobe lags the read by one cycle to match the memory read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_guardar_dato <= 4'b0000;
      r_valor_pixel  <= 2'd0;
    end else if (r_estado == E_LEER) begin
      r_guardar_dato <= 4'b0001 << r_k;
      r_valor_pixel  <= r_k;
    end else begin
      r_guardar_dato <= 4'b0000;
      r_valor_pixel  <= 2'd0;
    end
  end

endmodule
`default_nettype wire
